// File: rtl/inv_mon_pkg.sv
// inv_mon_pkg: shared state codes, pattern modes and LFSR taps for inv_drive_monitor.
`default_nettype none

package inv_mon_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_DRIVE  = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_SAMPLE = 3'd4;
  localparam state_t ST_FIN    = 3'd5;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_ONE    = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_LFSR   = 2'd3;

  // x^8+x^6+x^5+x^4+1 expressed as the bits XORed into the shift-left feedback
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/inv_lfsr8.sv
// inv_lfsr8: 8-bit Fibonacci LFSR, advances on adv, reloads SEED only on reset (rev 1.0).
`default_nettype none

module inv_lfsr8
  import inv_mon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic lfsr_bit
);

  // an all-zero state would lock the register up
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_bit = lfsr_q[0];

endmodule

`default_nettype wire

// File: rtl/inv_drive_monitor.sv
// inv_drive_monitor: drives an inverter with a pattern and checks out == ~in after a settle window.
// Optional macro INV_XZ_CHECK_EN adds x/z-as-mismatch sampling and the xz_seen output (rev 1.0).
`default_nettype none

module inv_drive_monitor
  import inv_mon_pkg::*;
#(
  parameter int         LEN_W      = 8,
  parameter int         ERR_W      = 8,
  parameter int         SETTLE_CYC = 2,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  output logic             drv_out,
  input  logic             inv_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef INV_XZ_CHECK_EN
  ,
  output logic             xz_seen
`endif
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic             drv_out_q, drv_out_d;
  logic             tog_q, tog_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             lfsr_adv;
  logic             lfsr_bit;
  logic             mismatch;

  inv_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (lfsr_adv),
    .lfsr_bit (lfsr_bit)
  );

`ifdef INV_XZ_CHECK_EN
  logic xz_seen_q, xz_seen_d;
  // a floating or contended switch output counts as a failed vector
  assign mismatch = (inv_in !== ~drv_out_q);
`else
  assign mismatch = (inv_in != ~drv_out_q);
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    vec_cnt_d = vec_cnt_q;
    set_cnt_d = set_cnt_q;
    drv_out_d = drv_out_q;
    tog_d     = tog_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    lfsr_adv  = 1'b0;
`ifdef INV_XZ_CHECK_EN
    xz_seen_d = xz_seen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          vec_cnt_d = len;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          tog_d     = 1'b1;
`ifdef INV_XZ_CHECK_EN
          xz_seen_d = 1'b0;
`endif
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (vec_cnt_q == '0) ? ST_FIN : ST_DRIVE;
      end
      ST_DRIVE: begin
        case (mode_q)
          MODE_ZERO: drv_out_d = 1'b0;
          MODE_ONE:  drv_out_d = 1'b1;
          MODE_TOGGLE: begin
            drv_out_d = tog_q;
            tog_d     = ~tog_q;
          end
          default: begin
            drv_out_d = lfsr_bit;
            lfsr_adv  = 1'b1;
          end
        endcase
        set_cnt_d = SET_LOAD;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_cnt_q == '0) state_d = ST_SAMPLE;
        else                 set_cnt_d = set_cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
`ifdef INV_XZ_CHECK_EN
        if ($isunknown(inv_in)) xz_seen_d = 1'b1;
`endif
        vec_cnt_d = vec_cnt_q - 1'b1;
        state_d   = (vec_cnt_q == LEN_W'(1)) ? ST_FIN : ST_DRIVE;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ZERO;
      vec_cnt_q <= '0;
      set_cnt_q <= '0;
      drv_out_q <= 1'b0;
      tog_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      vec_cnt_q <= vec_cnt_d;
      set_cnt_q <= set_cnt_d;
      drv_out_q <= drv_out_d;
      tog_q     <= tog_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef INV_XZ_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xz_seen_q <= 1'b0;
    else        xz_seen_q <= xz_seen_d;
  end
  assign xz_seen = xz_seen_q;
`endif

  assign drv_out = drv_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_drive_monitor.sv
// tb_inv_drive_monitor: directed runs, expected results queued at launch and popped by a done-driven monitor.
`default_nettype none

module tb_inv_drive_monitor;

  localparam int PER = 4;  // DRIVE + 2 SETTLE + SAMPLE clocks per vector

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] len = 8'd0;
  logic       drv_out;
  logic       inv_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [1:0] inv_sel = 2'd0;  // 0: true inverter, 1: follower, 2: floating

`ifdef INV_XZ_CHECK_EN
  logic xz_seen;
  assign inv_in = (inv_sel == 2'd2) ? 1'bz : (inv_sel == 2'd1) ? drv_out : ~drv_out;
`else
  assign inv_in = (inv_sel == 2'd1) ? drv_out : ~drv_out;
`endif

  inv_drive_monitor #(
    .LEN_W      (8),
    .ERR_W      (4),
    .SETTLE_CYC (2),
    .SEED       (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .len     (len),
    .drv_out (drv_out),
    .inv_in  (inv_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
`ifdef INV_XZ_CHECK_EN
    ,
    .xz_seen (xz_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    bit pass;
    bit drv;
    int lat;
  } res_t;

  res_t       res_q[$];
  bit         drv_q[$];
  res_t       r;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         t = 0;
  bit         busy_prev = 1'b0;
  bit         last_drv = 1'b0;
  int         tgt;
  // seed 8'hA5 with shift-left feedback of bits 7,5,4,3 emits 1,0,1,0,0 (LSB first)
  logic [4:0] lfsr_ref = 5'b00101;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit exp_bit(input logic [1:0] m, input int k);
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return (k % 2) == 0;
      default: return lfsr_ref[k];
    endcase
  endfunction

  // Monitor: drv_out mid-SETTLE of each vector, full result on each done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      t = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) t = 0;
      else                    t++;
      busy_prev = busy;
      if (busy && t >= 3 && ((t - 3) % PER) == 0) begin
        if (drv_q.size() == 0) check("drv_unexpected", drv_q.size(), 1);
        else                   check("drv_out", drv_out, drv_q.pop_front());
      end
      if (done) begin
        if (res_q.size() == 0) check("done_unexpected", res_q.size(), 1);
        else begin
          r = res_q.pop_front();
          check("err_cnt", err_cnt, r.err);
          check("pass", pass, r.pass);
          check("drv_final", drv_out, r.drv);
          check("done_latency", t, r.lat);
          check("busy_at_done", busy, 0);
        end
        done_cnt++;
      end
    end
  end

  task automatic launch(input logic [1:0] m, input logic [7:0] l, input int e_err, input bit e_pass);
    res_t e;
    for (int k = 0; k < int'(l); k++) begin
      last_drv = exp_bit(m, k);
      drv_q.push_back(last_drv);
    end
    e.err  = e_err;
    e.pass = e_pass;
    e.drv  = last_drv;
    e.lat  = 2 + PER * int'(l);
    res_q.push_back(e);
    tgt   = done_cnt + 1;
    mode  = m;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~m;
    len   = 8'd200;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt < tgt; i++) @(posedge clk);
    check("done_timeout", done_cnt >= tgt, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_drv_out", drv_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
`ifdef INV_XZ_CHECK_EN
    check("rst_xz_seen", xz_seen, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(2'd3, 8'd5, 0, 1'b1);      // LFSR from seed
    wait_done();
    launch(2'd2, 8'd4, 0, 1'b1);      // toggle 1,0,1,0
    wait_done();

    inv_sel = 2'd1;                   // non-inverting stage
    launch(2'd1, 8'd3, 3, 1'b0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("err_held", err_cnt, 3);
    check("pass_held", pass, 0);

    inv_sel = 2'd0;
    launch(2'd0, 8'd0, 0, 1'b1);      // empty run, drv_out untouched
    check("start_clears_err", err_cnt, 0);
    check("start_clears_pass", pass, 0);
    check("busy_after_accept", busy, 1);
    wait_done();

    inv_sel = 2'd1;
    launch(2'd1, 8'd255, 15, 1'b0);   // saturation at 4'hF
    wait_done();

    inv_sel = 2'd0;
    launch(2'd2, 8'd2, 0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;                     // ignored while busy
    mode  = 2'd1;
    len   = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    launch(2'd2, 8'd3, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;                     // abort mid-SETTLE
    #1;
    check("abort_drv_out", drv_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_err_cnt", err_cnt, 0);
    drv_q.delete();
    res_q.delete();
    #2;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    last_drv = 1'b0;
    launch(2'd3, 8'd5, 0, 1'b1);      // LFSR reseeded by reset
    wait_done();

`ifdef INV_XZ_CHECK_EN
    launch(2'd2, 8'd3, 1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    inv_sel = 2'd2;                   // float across vector 2 sample
    repeat (4) @(posedge clk);
    #1;
    inv_sel = 2'd0;
    wait_done();
    check("xz_seen", xz_seen, 1);
`endif

    check("queues_drained", drv_q.size() + res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
